tnn_neuron_stream: RTL



---
 rtl/tnn_pkg.sv | 22 ++
 rtl/tnn_lane_addsub.sv | 52 +++++
 rtl/tnn_neuron_stream.sv | 115 +++++++++++
 3 files changed

// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared types and elaboration helpers for the streaming threshold neuron
package tnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } tnn_state_e;

    // Two guard bits over the worst-case magnitude keep BIAS plus any frame sum in range.
    function automatic int acc_width(input int w, input int n_in);
        return w + $clog2(n_in) + 2;
    endfunction

    function automatic bit popmask_check(input int w, input int n_in, input int lanes, input int bias);
        int lim;
        lim = 1 << (w + $clog2(n_in));
        return (w > 0) && (n_in > 0) && (lanes > 0) && ((n_in % lanes) == 0)
            && (bias >= -lim) && (bias <= lim);
    endfunction

endpackage

// File: rtl/tnn_lane_addsub.sv
// rtl/tnn_lane_addsub.sv - signed sum of one beat's lanes, each added or subtracted by its input mask bit
module tnn_lane_addsub
    import tnn_pkg::*;
#(
    parameter int              W        = 3,
    parameter int              N_IN     = 6,
    parameter int              LANES    = 1,
    parameter logic [N_IN-1:0] POS_MASK = 6'b000011,
    parameter int              AW       = 8,
    parameter int              BW       = 3
) (
    input  logic [LANES*W-1:0]   data_i,
    input  logic [BW-1:0]        beat_i,
    output logic signed [AW-1:0] sum_o
);

    localparam int NB = N_IN / LANES;

    // Per-lane sign table indexed by beat; rows past the last beat are padding.
    logic [(1<<BW)-1:0] beat_mask [LANES];
    logic [LANES-1:0]   lane_sel;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        for (genvar b = 0; b < (1 << BW); b++) begin : g_beat
            if (b < NB) begin : g_in
                assign beat_mask[k][b] = POS_MASK[b*LANES+k];
            end else begin : g_pad
                assign beat_mask[k][b] = 1'b0;
            end
        end
        assign lane_sel[k] = beat_mask[k][beat_i];
    end

    logic signed [AW-1:0] sum_d;
    logic signed [AW-1:0] lane_ext;

    always_comb begin
        sum_d    = '0;
        lane_ext = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_ext = {{(AW-W){1'b0}}, data_i[k*W +: W]};
            if (lane_sel[k]) begin
                sum_d = sum_d + lane_ext;
            end else begin
                sum_d = sum_d - lane_ext;
            end
        end
    end

    assign sum_o = sum_d;

endmodule

// File: rtl/tnn_neuron_stream.sv
// rtl/tnn_neuron_stream.sv - streaming threshold neuron: one decision (sum_pos - sum_neg + BIAS > 0) per frame
module tnn_neuron_stream
    import tnn_pkg::*;
#(
    parameter int              W        = 3,
    parameter int              N_IN     = 6,
    parameter int              LANES    = 1,
    parameter logic [N_IN-1:0] POS_MASK = 6'b000011,
    parameter int signed       BIAS     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic               err
);

    localparam int AW = acc_width(W, N_IN);
    localparam int NB = N_IN / LANES;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic signed [AW-1:0] BIAS_ACC = AW'(BIAS);
    localparam logic [BW-1:0]        LAST_BEAT = BW'(NB - 1);

    if (!popmask_check(W, N_IN, LANES, BIAS)) begin : g_param_err
        $error("tnn_neuron_stream: N_IN must be a multiple of LANES and BIAS within range");
    end

    tnn_state_e           state_q;
    logic signed [AW-1:0] acc_q;
    logic [BW-1:0]        beat_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 out_bit_q;
    logic                 err_q;

    logic signed [AW-1:0] lane_sum;
    logic signed [AW-1:0] acc_d;
    logic                 beat_last;

    tnn_lane_addsub #(
        .W        (W),
        .N_IN     (N_IN),
        .LANES    (LANES),
        .POS_MASK (POS_MASK),
        .AW       (AW),
        .BW       (BW)
    ) u_addsub (
        .data_i (in_data),
        .beat_i (beat_q),
        .sum_o  (lane_sum)
    );

    assign acc_d     = acc_q + lane_sum;
    assign beat_last = (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beat_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    acc_q      <= BIAS_ACC;
                    in_ready_q <= 1'b1;
                    state_q    <= ACC;
                end
                ACC: begin
                    if (in_valid && in_ready_q) begin
                        acc_q <= acc_d;
                        // The beat count frames the data; in_last only flags disagreement.
                        if (in_last != beat_last) begin
                            err_q <= 1'b1;
                        end
                        if (beat_last) begin
                            out_bit_q   <= !acc_d[AW-1] && (acc_d != '0);
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            beat_q      <= '0;
                            state_q     <= OUT;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= BIAS_ACC;
                        in_ready_q  <= 1'b1;
                        state_q     <= ACC;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign err       = err_q;

endmodule
